// File: rtl/ofdm_cp_inserter_if.sv
// Stream bundle between the IFFT source, the CP inserter and the DAC-side sink.
// The slave modport is the inserter's view; master is the surrounding environment.
interface ofdm_cp_inserter_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic          in_sop;
    logic          in_eop;
    logic [1:0]    in_error;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;

    modport slave (
        input  in_valid, in_sop, in_eop, in_error, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_sop, out_eop, out_real, out_imag
    );

    modport master (
        output in_valid, in_sop, in_eop, in_error, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_sop, out_eop, out_real, out_imag
    );
endinterface

// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter: ping-pong frame store fed by the IFFT, emits the last CP
// samples followed by the whole frame with its own sop/eop framing.
//
// state  | meaning
// IDLE   | no full bank at rd_bank, output side waiting
// PREFIX | emitting samples N-CP..N-1 of the current bank
// BODY   | emitting samples 0..N-1 of the current bank
module ofdm_cp_inserter #(
    parameter int DW = 16,
    parameter int N  = 8,
    parameter int CP = 2,
    parameter int AW = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ofdm_cp_inserter_if.slave    bus,
    output logic                 frame_err,
    output logic [15:0]          frames_out
);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
    localparam logic [AW-1:0] PFX_START = AW'(N - CP);

    typedef enum logic [1:0] {IDLE, PREFIX, BODY} rd_state_e;

    logic [DW-1:0] mem_re [0:2*N-1];
    logic [DW-1:0] mem_im [0:2*N-1];

    logic [1:0]    bank_full_q, bank_full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          poison_q, poison_d;
    logic          in_ready_q, in_ready_d;
    logic          frame_err_q, frame_err_d;
    logic [15:0]   frames_q, frames_d;
    rd_state_e     state_q, state_d;

    logic          out_valid_q, out_valid_d;
    logic          out_sop_q, out_sop_d;
    logic          out_eop_q, out_eop_d;
    logic [DW-1:0] out_real_q, out_real_d;
    logic [DW-1:0] out_imag_q, out_imag_d;

    logic          accept;
    logic          mem_we;
    logic [AW:0]   mem_waddr;
    logic [AW:0]   mem_raddr;
    logic          set_full;
    logic          clr_full;
    logic          load;
    logic          beat_take;
    logic          other_full;

    assign accept    = bus.in_valid & in_ready_q;
    assign load      = ~out_valid_q | bus.out_ready;
    assign beat_take = load & (state_q != IDLE);
    assign mem_raddr = {rd_bank_q, rd_idx_q};

    // Write side: frame validation and bank filling
    always_comb begin
        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        poison_d    = poison_q;
        set_full    = 1'b0;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = {wr_bank_q, wr_idx_q};
        if (accept) begin
            if (bus.in_sop) begin
                frame_err_d = (wr_idx_q != '0);
                mem_we      = 1'b1;
                mem_waddr   = {wr_bank_q, {AW{1'b0}}};
                wr_idx_d    = AW'(1);
                poison_d    = |bus.in_error;
            end else if (wr_idx_q == '0) begin
                frame_err_d = 1'b1;
            end else if (wr_idx_q == LAST_IDX) begin
                wr_idx_d = '0;
                if (bus.in_eop) begin
                    mem_we = 1'b1;
                    if (poison_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        set_full  = 1'b1;
                        wr_bank_d = ~wr_bank_q;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end else if (bus.in_eop) begin
                frame_err_d = 1'b1;
                wr_idx_d    = '0;
            end else begin
                mem_we   = 1'b1;
                wr_idx_d = wr_idx_q + AW'(1);
            end
        end
    end

    // A bank filled this very cycle still counts, so back-to-back frames never bubble
    assign other_full = bank_full_q[~rd_bank_q] | (set_full & (wr_bank_q == ~rd_bank_q));

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        rd_bank_d = rd_bank_q;
        clr_full = 1'b0;
        frames_d = frames_q;
        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = PREFIX;
                    rd_idx_d = PFX_START;
                end
            end
            PREFIX: begin
                if (beat_take) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = BODY;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
            end
            BODY: begin
                if (beat_take) begin
                    if (rd_idx_q == LAST_IDX) begin
                        clr_full  = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        frames_d  = frames_q + 16'd1;
                        if (other_full) begin
                            state_d  = PREFIX;
                            rd_idx_d = PFX_START;
                        end else begin
                            state_d  = IDLE;
                            rd_idx_d = '0;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                rd_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        bank_full_d = bank_full_q;
        if (clr_full) bank_full_d[rd_bank_q] = 1'b0;
        if (set_full) bank_full_d[wr_bank_q] = 1'b1;
        in_ready_d = ~bank_full_d[wr_bank_d];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        if (load) begin
            out_valid_d = (state_q != IDLE);
            out_sop_d   = (state_q == PREFIX) && (rd_idx_q == PFX_START);
            out_eop_d   = (state_q == BODY) && (rd_idx_q == LAST_IDX);
            if (state_q != IDLE) begin
                out_real_d = mem_re[mem_raddr];
                out_imag_d = mem_im[mem_raddr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            poison_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frames_q    <= '0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            poison_q    <= poison_d;
            in_ready_q  <= in_ready_d;
            frame_err_q <= frame_err_d;
            frames_q    <= frames_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
        end
    end

    // Sample store carries no reset; stale contents are never read before being written
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_re[mem_waddr] <= bus.in_real;
            mem_im[mem_waddr] <= bus.in_imag;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_real  = out_real_q;
    assign bus.out_imag  = out_imag_q;
    assign frame_err     = frame_err_q;
    assign frames_out    = frames_q;
endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Scoreboard bench for ofdm_cp_inserter: a list-based frame model predicts output beats,
// a negedge monitor compares every accepted output beat and stall stability.
module tb_ofdm_cp_inserter;
    localparam int DW = 16;
    localparam int N  = 8;
    localparam int CP = 2;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        frame_err;
    logic [15:0] frames_out;

    ofdm_cp_inserter_if #(.DW(DW)) bus ();

    ofdm_cp_inserter #(.DW(DW), .N(N), .CP(CP), .AW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .frame_err  (frame_err),
        .frames_out (frames_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t         exp_q[$];
    logic [31:0]   cur[$];
    bit            in_frame = 0;
    bit            poison = 0;
    int            model_err = 0;
    int            model_frames = 0;
    int            eop_cyc = 0;

    int            err_seen = 0;
    int            rise_cyc = 0;
    bit            prev_valid = 0;
    int            beat_cnt = 0;
    int            beat_first = 0;
    int            beat_last = 0;
    bit            hold_pending = 0;
    logic [34:0]   hold_val;

    int            rdy_mode = 0;
    int            pi = 0;
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [DW-1:0] fr_re [N];
    logic [DW-1:0] fr_im [N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                bus.out_ready = pat[pi];
                pi = (pi + 1) % 4;
            end
            2: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b1;
        endcase
    end

    // Reference model: frames are lists of accepted samples, emitted as tail(CP) ++ whole list
    always @(negedge clk) begin
        if (reset_n && bus.in_valid && bus.in_ready) begin
            if (bus.in_sop) begin
                if (in_frame) model_err++;
                cur.delete();
                cur.push_back({bus.in_real, bus.in_imag});
                poison = |bus.in_error;
                in_frame = 1;
            end else if (!in_frame) begin
                model_err++;
            end else begin
                cur.push_back({bus.in_real, bus.in_imag});
                if (cur.size() == N) begin
                    in_frame = 0;
                    if (bus.in_eop && !poison) begin
                        for (int i = N - CP; i < N; i++)
                            exp_q.push_back({cur[i], (i == N - CP), 1'b0});
                        for (int i = 0; i < N; i++)
                            exp_q.push_back({cur[i], 1'b0, (i == N - 1)});
                        model_frames++;
                        eop_cyc = cyc;
                    end else begin
                        model_err++;
                    end
                end else if (bus.in_eop) begin
                    model_err++;
                    in_frame = 0;
                end
            end
        end

        if (frame_err) err_seen++;
        if (bus.out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.out_valid;

        if (hold_pending && reset_n)
            chk("stall_hold", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_real, bus.out_imag}, hold_val);
        hold_pending = reset_n && bus.out_valid && !bus.out_ready;
        hold_val = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_real, bus.out_imag};

        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {bus.out_real, bus.out_imag}, 0);
                chk("unexpected_beat_count", 1, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("out_beat", {bus.out_real, bus.out_imag, bus.out_sop, bus.out_eop}, e);
            end
            if (beat_cnt == 0) beat_first = cyc;
            beat_last = cyc;
            beat_cnt++;
        end
    end

    task automatic send_beat(input bit sop, input bit eop, input logic [1:0] err,
                             input logic [DW-1:0] re, input logic [DW-1:0] im);
        int w;
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_error = err;
        bus.in_real  = re;
        bus.in_imag  = im;
        for (w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (w == 200) chk("in_ready_timeout", w, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_error = 2'b00;
    endtask

    task automatic send_frame(input logic [1:0] err0, input bit gaps);
        for (int i = 0; i < N; i++) begin
            int g;
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send_beat(i == 0, i == N - 1, (i == 0) ? err0 : 2'b00, fr_re[i], fr_im[i]);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = DW'($urandom);
            fr_im[i] = DW'($urandom);
        end
    endtask

    task automatic base_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = DW'(i + 1);
            fr_im[i] = DW'(-(i + 1));
        end
    endtask

    task automatic drain();
        int w;
        for (w = 0; w < 500; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        chk("drain_timeout", w < 500, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_error = 2'b00;
        bus.in_real  = '0;
        bus.in_imag  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_frames_out", frames_out, 0);
        chk("reset_frame_err", frame_err, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", bus.in_ready, 1);

        // single legal frame: 7,8,1..8
        base_frame();
        send_frame(2'b00, 0);
        drain();
        chk("first_valid_latency", rise_cyc - eop_cyc, 3);
        chk("frames_single", frames_out, 1);
        chk("frame_err_single", err_seen, 0);

        // four back-to-back frames, output must be gapless
        beat_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame(2'b00, 0);
        end
        drain();
        chk("b2b_beats", beat_cnt, 40);
        chk("b2b_span", beat_last - beat_first, 39);
        chk("frames_b2b", frames_out, 5);

        // stalled output
        rdy_mode = 1;
        base_frame();
        send_frame(2'b00, 0);
        drain();
        rdy_mode = 0;
        chk("frames_stall", frames_out, 6);

        // malformed: early eop, legal frame, restart at index 3
        for (int i = 0; i <= 5; i++)
            send_beat(i == 0, i == 5, 2'b00, DW'(100 + i), DW'(200 + i));
        rand_frame();
        send_frame(2'b00, 0);
        for (int i = 0; i < 3; i++)
            send_beat(i == 0, 1'b0, 2'b00, DW'(300 + i), DW'(400 + i));
        rand_frame();
        send_frame(2'b00, 0);
        drain();
        chk("malformed_err_count", err_seen, 2);
        chk("malformed_frames", frames_out, 8);

        // poisoned frame
        rand_frame();
        send_frame(2'b01, 0);
        drain();
        chk("poison_err_count", err_seen, 3);
        chk("poison_frames", frames_out, 8);

        // randomized traffic with gaps and random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 16; f++) begin
            rand_frame();
            send_frame(2'b00, 1);
        end
        drain();
        rdy_mode = 0;
        chk("random_frames", frames_out, model_frames);
        chk("random_err_count", err_seen, model_err);

        // reset during PREFIX
        base_frame();
        send_frame(2'b00, 0);
        begin
            int w;
            for (w = 0; w < 100; w++) begin
                @(negedge clk);
                if (bus.out_valid && bus.out_sop) break;
            end
            chk("sop_wait_timeout", w < 100, 1);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        cur.delete();
        in_frame = 0;
        model_frames = 0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_sop", bus.out_sop, 0);
        chk("midrst_out_eop", bus.out_eop, 0);
        chk("midrst_out_data", {bus.out_real, bus.out_imag}, 0);
        chk("midrst_frames_out", frames_out, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("midrst_in_ready_held", bus.in_ready, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(2'b00, 0);
        drain();
        chk("post_reset_frames", frames_out, 1);
        chk("post_reset_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
